// File: rtl/dmem_lat_ctrl.sv
// Data memory with a valid/ready request channel, configurable read latency,
// access checking, a saturating error counter and a combinational debug port.
module dmem_lat_ctrl #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS),
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [15:0] err_count,
    input  logic [31:0] dbg_addr,
    output logic [31:0] dbg_data
);

    // state  | meaning
    // S_IDLE | no request outstanding, ready to accept
    // S_WAIT | request accepted, latency counter running, not ready
    // S_RESP | response strobe this cycle, ready to accept the next request
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_cnt;
    logic [31:0]        r_mem [DEPTH_WORDS];
    logic [31:0]        r_pipe_data;
    logic               r_pipe_err;
    logic [31:0]        r_resp_rdata;
    logic               r_resp_err;
    logic [15:0]        r_err_count;

    logic               w_accept;
    logic               w_err;
    logic [ADDR_W-1:0]  w_idx;
    logic [31:0]        w_rd_word;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load_val;
    logic [31:0]        w_result;
    logic [3:0]         w_be;
    logic [31:0]        w_wlanes;
    logic               w_commit;
    logic               w_unused_dbg;

    assign w_accept     = req_valid & req_ready;
    assign w_idx        = req_addr[ADDR_W+1:2];
    assign w_rd_word    = r_mem[w_idx];
    assign w_commit     = w_accept & req_we & ~w_err;
    assign dbg_data     = r_mem[dbg_addr[ADDR_W+1:2]];
    assign w_unused_dbg = ^{dbg_addr[31:ADDR_W+2], dbg_addr[1:0]};

    assign resp_rdata   = r_resp_rdata;
    assign resp_err     = r_resp_err;
    assign err_count    = r_err_count;

    // Access legality: bad type, unsigned store, misalignment, out of range.
    always_comb begin
        w_err = 1'b0;
        if (req_type == 3'd3 || req_type == 3'd6 || req_type == 3'd7) w_err = 1'b1;
        if (req_we && req_type[2])                                    w_err = 1'b1;
        if (req_type[1:0] == 2'd1 && req_addr[0])                     w_err = 1'b1;
        if (req_type == 3'd2 && req_addr[1:0] != 2'd0)                w_err = 1'b1;
        if (req_addr[31:ADDR_W+2] != '0)                              w_err = 1'b1;
    end

    // Load lane select and extension; stores and rejected accesses return 0.
    always_comb begin
        w_byte = w_rd_word[8*req_addr[1:0] +: 8];
        w_half = req_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];
        case (req_type)
            3'd0:    w_load_val = {{24{w_byte[7]}}, w_byte};
            3'd1:    w_load_val = {{16{w_half[15]}}, w_half};
            3'd2:    w_load_val = w_rd_word;
            3'd4:    w_load_val = {24'h0, w_byte};
            3'd5:    w_load_val = {16'h0, w_half};
            default: w_load_val = 32'h0;
        endcase
        w_result = (req_we || w_err) ? 32'h0 : w_load_val;
    end

    // Byte enables and replicated write data for the store lanes.
    always_comb begin
        case (req_type[1:0])
            2'd0: begin
                w_be     = 4'b0001 << req_addr[1:0];
                w_wlanes = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                w_be     = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{req_wdata[15:0]}};
            end
            default: begin
                w_be     = 4'b1111;
                w_wlanes = req_wdata;
            end
        endcase
    end

    // Memory array: store commits at the accept edge, never cleared by reset.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
            end
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b1;
        resp_valid = 1'b0;
        case (r_state)
            S_WAIT: begin
                req_ready = 1'b0;
                if (r_cnt == 4'd1) w_next = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (w_accept) w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
                else          w_next = S_IDLE;
            end
            default: begin
                if (w_accept) w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
            end
        endcase
    end

    // State, latency counter, pipeline and response registers, error counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_pipe_data  <= 32'h0;
            r_pipe_err   <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_err   <= 1'b0;
            r_err_count  <= 16'h0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt       <= 4'(LATENCY - 1);
                r_pipe_data <= w_result;
                r_pipe_err  <= w_err;
                if (w_err && r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // With LATENCY 1 the response comes straight from the accept edge.
            if (w_next == S_RESP) begin
                r_resp_rdata <= w_accept ? w_result : r_pipe_data;
                r_resp_err   <= w_accept ? w_err    : r_pipe_err;
            end
        end
    end

endmodule
